// File: rtl/msi_message_generator_if.sv
// rtl/msi_message_generator_if.sv - MSI write-request handshake toward the TLP builder
//
// Groups the valid/ready request channel that carries one MSI memory write.
//   tx_valid     request valid (held until accepted)
//   tx_ready     TLP builder accepts the request
//   tx_addr      write address, dword aligned
//   tx_is_64bit  1 = 4DW header (64-bit address)
//   tx_data      write payload
interface msi_message_generator_if;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] tx_addr;
  logic        tx_is_64bit;
  logic [31:0] tx_data;

  modport master (
    output tx_valid, tx_addr, tx_is_64bit, tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_addr, tx_is_64bit, tx_data,
    output tx_ready
  );
endinterface

// File: rtl/msi_message_generator.sv
// rtl/msi_message_generator.sv - PCIe MSI transmit engine with pending bits and round-robin grant
//
// Collects per-vector interrupt requests into the Pending Bits, picks an
// unmasked pending vector round-robin and issues one MSI memory write per
// grant over the tx handshake.
//   clk, rst_n               clock, asynchronous active-low reset
//   msi_enable               MSI Enable from the capability control
//   multiple_message_enable  MME; allocated vectors = 1 << MME (clamped)
//   addr_64bit_capable       function may use a 64-bit message address
//   msg_addr, msg_data       Message Address / Message Data
//   mask_bits                per-vector mask (1 = masked)
//   irq_req                  per-vector one-cycle request pulses
//   tx                       MSI write request channel (master side)
//   pending_bits             Pending Bits register value
//   busy                     high while a request is outstanding
module msi_message_generator #(
  parameter int MAX_VECTORS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   msi_enable,
  input  logic [2:0]             multiple_message_enable,
  input  logic                   addr_64bit_capable,
  input  logic [63:0]            msg_addr,
  input  logic [15:0]            msg_data,
  input  logic [MAX_VECTORS-1:0] mask_bits,
  input  logic [MAX_VECTORS-1:0] irq_req,
  msi_message_generator_if.master tx,
  output logic [MAX_VECTORS-1:0] pending_bits,
  output logic                   busy
);

  localparam int MME_MAX = $clog2(MAX_VECTORS);
  localparam int PW      = (MAX_VECTORS > 1) ? $clog2(MAX_VECTORS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [MAX_VECTORS-1:0] pending_q, pending_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [63:0]            tx_addr_q, tx_addr_d;
  logic [31:0]            tx_data_q, tx_data_d;
  logic                   tx_is_64bit_q, tx_is_64bit_d;

  logic [2:0]             mme_eff;
  int                     alloc_n;
  logic [MAX_VECTORS-1:0] folded;
  logic [MAX_VECTORS-1:0] eligible;
  logic                   grant_found;
  logic [PW-1:0]          grant_idx;
  logic                   accept;
  logic                   tx_valid_o;
  logic                   busy_o;
  logic [15:0]            dmask;

  // MME beyond what the function implements behaves as the largest legal value.
  always_comb begin
    mme_eff = multiple_message_enable;
    if (int'(multiple_message_enable) > MME_MAX) mme_eff = 3'(MME_MAX);
    alloc_n = 1 << mme_eff;
  end

  // Requests above the allocation fold onto the low vectors; collisions coalesce.
  always_comb begin
    folded = '0;
    for (int i = 0; i < MAX_VECTORS; i++) begin
      if (irq_req[i]) folded[i & (alloc_n - 1)] = 1'b1;
    end
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < MAX_VECTORS; i++) begin
      eligible[i] = pending_q[i] && !mask_bits[i] && (i < alloc_n);
    end
  end

  // Search starts one past the last granted vector and wraps at the allocation,
  // so a pointer left over from a larger MME still lands inside the range.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < MAX_VECTORS; k++) begin
      if (!grant_found && (k < alloc_n) &&
          eligible[(int'(ptr_q) + 1 + k) & (alloc_n - 1)]) begin
        grant_found = 1'b1;
        grant_idx   = PW'((int'(ptr_q) + 1 + k) & (alloc_n - 1));
      end
    end
  end

  assign accept = (state_q == SEND) && tx.tx_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      ptr_q         <= PW'(MAX_VECTORS - 1);
      tx_addr_q     <= '0;
      tx_data_q     <= '0;
      tx_is_64bit_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      ptr_q         <= ptr_d;
      tx_addr_q     <= tx_addr_d;
      tx_data_q     <= tx_data_d;
      tx_is_64bit_q <= tx_is_64bit_d;
    end
  end

  // Next-state logic. A request in flight is never withdrawn, even if MSI is disabled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (msi_enable && grant_found) state_d = SEND;
      SEND: if (tx.tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    tx_valid_o = 1'b0;
    busy_o     = 1'b0;
    if (state_q == SEND) begin
      tx_valid_o = 1'b1;
      busy_o     = 1'b1;
    end
  end

  // Datapath: payload latches only on the grant; pending clear loses to a same-cycle set.
  always_comb begin
    ptr_d         = ptr_q;
    tx_addr_d     = tx_addr_q;
    tx_data_d     = tx_data_q;
    tx_is_64bit_d = tx_is_64bit_q;
    dmask         = (16'd1 << mme_eff) - 16'd1;

    if ((state_q == IDLE) && (state_d == SEND)) begin
      ptr_d     = grant_idx;
      tx_data_d = {16'h0, (msg_data & ~dmask) | (16'(grant_idx) & dmask)};
      if (addr_64bit_capable && (msg_addr[63:32] != 32'h0)) begin
        tx_is_64bit_d = 1'b1;
        tx_addr_d     = msg_addr & ~64'h3;
      end else begin
        tx_is_64bit_d = 1'b0;
        tx_addr_d     = {32'h0, msg_addr[31:0] & ~32'h3};
      end
    end

    pending_d = pending_q;
    if (accept) pending_d[ptr_q] = 1'b0;
    pending_d = pending_d | folded;
    if (!msi_enable) pending_d = '0;
  end

  assign tx.tx_valid    = tx_valid_o;
  assign tx.tx_addr     = tx_addr_q;
  assign tx.tx_data     = tx_data_q;
  assign tx.tx_is_64bit = tx_is_64bit_q;
  assign pending_bits   = pending_q;
  assign busy           = busy_o;

endmodule

// File: tb/tb_msi_message_generator.sv
// tb/tb_msi_message_generator.sv - scoreboard bench for msi_message_generator
module tb_msi_message_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msi_enable = 1'b0;
  logic [2:0]  mme = 3'd0;
  logic        cap64 = 1'b0;
  logic [63:0] msg_addr = 64'h0;
  logic [15:0] msg_data = 16'h0;
  logic [31:0] mask_bits = '0;
  logic [31:0] irq_req = '0;
  logic [31:0] pending_bits;
  logic        busy;

  msi_message_generator_if bus ();

  msi_message_generator #(.MAX_VECTORS(32)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .msi_enable              (msi_enable),
    .multiple_message_enable (mme),
    .addr_64bit_capable      (cap64),
    .msg_addr                (msg_addr),
    .msg_data                (msg_data),
    .mask_bits               (mask_bits),
    .irq_req                 (irq_req),
    .tx                      (bus.master),
    .pending_bits            (pending_bits),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic        is64;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted request must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_msg: got addr %h data %h expected none", bus.tx_addr, bus.tx_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("msg_addr", bus.tx_addr, e.addr);
        chk("msg_is64", {63'h0, bus.tx_is_64bit}, {63'h0, e.is64});
        chk("msg_data", {32'h0, bus.tx_data}, {32'h0, e.data});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] v);
    irq_req = v;
    tick(1);
    irq_req = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic push(input logic [63:0] a, input logic i, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.is64 = i;
    e.data = d;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.tx_ready = 1'b1;
    msg_data     = 16'h4A00;
    msg_addr     = 64'h0000_0000_FEE0_0000;
    do_reset();

    chk("rst_valid", {63'h0, bus.tx_valid}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_addr", bus.tx_addr, 64'h0);
    chk("rst_data", {32'h0, bus.tx_data}, 64'h0);
    chk("rst_pend", {32'h0, pending_bits}, 64'h0);

    // Single vector, MME=0
    msi_enable = 1'b1;
    push(64'hFEE0_0000, 1'b0, 32'h0000_4A00);
    pulse(32'h1);
    chk("t1_pend_set", {32'h0, pending_bits}, 64'h1);
    chk("t1_valid_lo", {63'h0, bus.tx_valid}, 64'h0);
    tick(1);
    chk("t1_valid_hi", {63'h0, bus.tx_valid}, 64'h1);
    chk("t1_busy", {63'h0, busy}, 64'h1);
    tick(1);
    chk("t1_valid_done", {63'h0, bus.tx_valid}, 64'h0);
    chk("t1_pend_clr", {32'h0, pending_bits}, 64'h0);

    // Masked vector held pending until unmasked
    do_reset();
    mme = 3'd3;
    mask_bits = 32'h20;
    pulse(32'h20);
    chk("t2_pend", {32'h0, pending_bits}, 64'h20);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t2_masked_valid", {63'h0, bus.tx_valid}, 64'h0);
    end
    push(64'hFEE0_0000, 1'b0, 32'h0000_4A05);
    mask_bits = '0;
    tick(1);
    chk("t2_valid_hi", {63'h0, bus.tx_valid}, 64'h1);
    tick(1);
    chk("t2_pend_clr", {32'h0, pending_bits}, 64'h0);

    // Round-robin order and wrap, MME=2
    do_reset();
    mme = 3'd2;
    push(64'hFEE0_0000, 1'b0, 32'h0000_4A01);
    push(64'hFEE0_0000, 1'b0, 32'h0000_4A02);
    push(64'hFEE0_0000, 1'b0, 32'h0000_4A03);
    pulse(32'hE);
    chk("t3_pend", {32'h0, pending_bits}, 64'hE);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("t3_spacing", {63'h0, bus.tx_valid}, (i % 2 == 0) ? 64'h1 : 64'h0);
    end
    push(64'hFEE0_0000, 1'b0, 32'h0000_4A01);
    pulse(32'h2);
    tick(2);
    chk("t3_wrap_pend", {32'h0, pending_bits}, 64'h0);

    // Folding and 64-bit address, MME=1
    do_reset();
    mme = 3'd1;
    cap64 = 1'b1;
    msg_data = 16'h4A01;
    msg_addr = 64'h0000_0001_FEE0_0003;
    push(64'h0000_0001_FEE0_0000, 1'b1, 32'h0000_4A00);
    pulse(32'h40);
    chk("t4_fold_pend", {32'h0, pending_bits}, 64'h1);
    tick(1);
    chk("t4_is64", {63'h0, bus.tx_is_64bit}, 64'h1);
    tick(1);
    chk("t4_pend_clr", {32'h0, pending_bits}, 64'h0);

    // Backpressure and set-wins on accept; 32-bit address without capability
    do_reset();
    mme = 3'd0;
    cap64 = 1'b0;
    msg_data = 16'h4A00;
    msg_addr = 64'h0000_0001_FEE0_0000;
    bus.tx_ready = 1'b0;
    push(64'hFEE0_0000, 1'b0, 32'h0000_4A00);
    push(64'hFEE0_0000, 1'b0, 32'h0000_4A00);
    pulse(32'h1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t5_hold_valid", {63'h0, bus.tx_valid}, 64'h1);
      chk("t5_hold_data", {32'h0, bus.tx_data}, 64'h4A00);
      chk("t5_hold_addr", bus.tx_addr, 64'hFEE0_0000);
    end
    bus.tx_ready = 1'b1;
    pulse(32'h1);
    chk("t5_setwins_pend", {32'h0, pending_bits}, 64'h1);
    chk("t5_gap", {63'h0, bus.tx_valid}, 64'h0);
    tick(1);
    chk("t5_second", {63'h0, bus.tx_valid}, 64'h1);
    tick(1);
    chk("t5_pend_clr", {32'h0, pending_bits}, 64'h0);

    // Enable drop during SEND, then reset mid-SEND
    do_reset();
    mme = 3'd2;
    msg_addr = 64'h0000_0000_FEE0_0000;
    bus.tx_ready = 1'b0;
    push(64'hFEE0_0000, 1'b0, 32'h0000_4A00);
    pulse(32'h3);
    chk("t6_valid", {63'h0, bus.tx_valid}, 64'h0);
    tick(1);
    msi_enable = 1'b0;
    tick(1);
    chk("t6_pend_clr", {32'h0, pending_bits}, 64'h0);
    chk("t6_held", {63'h0, bus.tx_valid}, 64'h1);
    bus.tx_ready = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_grant", {63'h0, bus.tx_valid}, 64'h0);
      tick(1);
    end
    pulse(32'h4);
    chk("t6_dropped", {32'h0, pending_bits}, 64'h0);

    msi_enable = 1'b1;
    bus.tx_ready = 1'b0;
    pulse(32'h8);
    tick(1);
    chk("t6_send", {63'h0, bus.tx_valid}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {63'h0, bus.tx_valid}, 64'h0);
    chk("t6_rst_busy", {63'h0, busy}, 64'h0);
    chk("t6_rst_data", {32'h0, bus.tx_data}, 64'h0);
    chk("t6_rst_pend", {32'h0, pending_bits}, 64'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
